// File: rtl/cpu_io_responder.sv
// cpu_io_responder
//
// Device-side responder for the cpu_top external I/O port. Words the CPU
// strobes out (cpu_y1/cpu_y2) are queued in a small first-word-fall-through
// FIFO that the host drains through a valid/ready port. The word returned to
// the CPU (cpu_x2) is a host-loaded register, and the CPU's ready input
// (cpu_x1) reports that the FIFO has space.
//
// Ports:
//   clk            single clock, all state updates on the rising edge
//   rst            asynchronous active-low reset
//   cpu_y1/cpu_y2  CPU write strobe / word
//   cpu_x1         ready to CPU, 1 = FIFO not full
//   cpu_x2         word returned to the CPU
//   host_rd_*      FIFO head, valid/ready handshake, zero read latency
//   host_wr_en/    load cpu_x2 register
//   host_wr_data
//   level          FIFO occupancy, 0..DEPTH
//   overflow       sticky dropped-write flag
//
// Optional feature: define CPU_IO_OVF_EN to build the sticky overflow flag.
// Without it, overflow is tied to 0 and writes while full are dropped
// silently. FIFO behaviour is identical in both builds.

module cpu_io_responder #(
  parameter int DATA_W = 30,
  parameter int DEPTH  = 4,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_y1,
  input  logic [DATA_W-1:0] cpu_y2,
  output logic              cpu_x1,
  output logic [DATA_W-1:0] cpu_x2,
  output logic              host_rd_valid,
  output logic [DATA_W-1:0] host_rd_data,
  input  logic              host_rd_ready,
  input  logic              host_wr_en,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic [AW:0]       level,
  output logic              overflow
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [AW:0]       count;
  logic [DATA_W-1:0] x2_reg;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  // Flags come from registered count only, so cpu_x1 never depends
  // combinationally on this cycle's pop: a full FIFO refuses the write even
  // when the host drains the head in the same cycle.
  assign full  = (count == FULL_LVL);
  assign empty = (count == '0);
  assign push  = cpu_y1 && !full;
  assign pop   = !empty && host_rd_ready;

  assign cpu_x1        = !full;
  assign cpu_x2        = x2_reg;
  assign host_rd_valid = !empty;
  assign host_rd_data  = mem[rd_ptr];
  assign level         = count;

  // Storage needs no reset; entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cpu_y2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      x2_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (host_wr_en) begin
        x2_reg <= host_wr_data;
      end
    end
  end

`ifdef CPU_IO_OVF_EN
  logic ovf_reg;

  // Sticky until reset; draining the FIFO does not clear it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_reg <= 1'b0;
    end else if (cpu_y1 && full) begin
      ovf_reg <= 1'b1;
    end
  end

  assign overflow = ovf_reg;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_io_responder.sv
module tb_cpu_io_responder;

  localparam int DATA_W = 30;
  localparam int DEPTH  = 4;
  localparam int AW     = 2;

  logic              clk;
  logic              rst;
  logic              cpu_y1;
  logic [DATA_W-1:0] cpu_y2;
  logic              cpu_x1;
  logic [DATA_W-1:0] cpu_x2;
  logic              host_rd_valid;
  logic [DATA_W-1:0] host_rd_data;
  logic              host_rd_ready;
  logic              host_wr_en;
  logic [DATA_W-1:0] host_wr_data;
  logic [AW:0]       level;
  logic              overflow;

  cpu_io_responder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_y1        (cpu_y1),
    .cpu_y2        (cpu_y2),
    .cpu_x1        (cpu_x1),
    .cpu_x2        (cpu_x2),
    .host_rd_valid (host_rd_valid),
    .host_rd_data  (host_rd_data),
    .host_rd_ready (host_rd_ready),
    .host_wr_en    (host_wr_en),
    .host_wr_data  (host_wr_data),
    .level         (level),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of words in arrival order, the returned word,
  // and the sticky overflow flag.
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_x2;
  logic              m_ovf;
  int                vectors;
  int                errors;
  int                max_level;

  function automatic logic ovf_enabled();
`ifdef CPU_IO_OVF_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_x2  = '0;
    m_ovf = 1'b0;
  endtask

  task automatic check(input string tag);
    logic              e_x1;
    logic              e_valid;
    logic [AW:0]       e_level;
    e_x1    = (q.size() < DEPTH);
    e_valid = (q.size() != 0);
    e_level = (AW+1)'(q.size());
    vectors++;
    assert (cpu_x1 === e_x1) else begin
      errors++;
      $error("FAIL %s cpu_x1 observed=%0b expected=%0b", tag, cpu_x1, e_x1);
    end
    vectors++;
    assert (host_rd_valid === e_valid) else begin
      errors++;
      $error("FAIL %s host_rd_valid observed=%0b expected=%0b", tag, host_rd_valid, e_valid);
    end
    vectors++;
    assert (level === e_level) else begin
      errors++;
      $error("FAIL %s level observed=%0d expected=%0d", tag, level, e_level);
    end
    vectors++;
    assert (cpu_x2 === m_x2) else begin
      errors++;
      $error("FAIL %s cpu_x2 observed=%h expected=%h", tag, cpu_x2, m_x2);
    end
    vectors++;
    assert (overflow === m_ovf) else begin
      errors++;
      $error("FAIL %s overflow observed=%0b expected=%0b", tag, overflow, m_ovf);
    end
    if (e_valid) begin
      vectors++;
      assert (host_rd_data === q[0]) else begin
        errors++;
        $error("FAIL %s host_rd_data observed=%h expected=%h", tag, host_rd_data, q[0]);
      end
    end
  endtask

  // Called at a falling edge: drive inputs, take the rising edge, update the
  // model from the pre-edge state, return to idle inputs at the next falling
  // edge.
  task automatic step(input logic y1, input logic [DATA_W-1:0] y2,
                      input logic rr, input logic we,
                      input logic [DATA_W-1:0] wd);
    logic do_push;
    logic do_pop;
    cpu_y1        = y1;
    cpu_y2        = y2;
    host_rd_ready = rr;
    host_wr_en    = we;
    host_wr_data  = wd;
    do_push = y1 && (q.size() < DEPTH);
    do_pop  = rr && (q.size() != 0);
    @(posedge clk);
    if (y1 && q.size() == DEPTH && ovf_enabled()) m_ovf = 1'b1;
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(y2);
    if (we) m_x2 = wd;
    if (q.size() > max_level) max_level = q.size();
    @(negedge clk);
    cpu_y1        = 1'b0;
    cpu_y2        = '0;
    host_rd_ready = 1'b0;
    host_wr_en    = 1'b0;
    host_wr_data  = '0;
  endtask

  initial begin
    logic [DATA_W-1:0] w;
    logic [DATA_W-1:0] got;
    vectors = 0;
    errors  = 0;
    rst           = 1'b0;
    cpu_y1        = 1'b0;
    cpu_y2        = '0;
    host_rd_ready = 1'b0;
    host_wr_en    = 1'b0;
    host_wr_data  = '0;
    model_reset();

    repeat (2) @(negedge clk);
    check("reset_initial");
    rst = 1'b1;
    @(negedge clk);
    check("after_release");

    // Reset mid-stream after three pushes, with a loaded cpu_x2.
    step(1'b0, '0, 1'b0, 1'b1, 30'h1555_5555);
    for (int i = 0; i < 3; i++) step(1'b1, 30'(i + 100), 1'b0, 1'b0, '0);
    check("pre_reset");
    rst = 1'b0;
    #1;
    model_reset();
    check("reset_mid");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_release");

    // Ordering and wrap: ready from the second push onward.
    max_level = 0;
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 30'(i), (i >= 2), 1'b0, '0);
      check("order");
    end
    for (int i = 0; i < DEPTH && q.size() != 0; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, '0);
      check("order_drain");
    end
    vectors++;
    assert (max_level <= 2) else begin
      errors++;
      $error("FAIL order_max_level observed=%0d expected<=2", max_level);
    end

    // Full boundary.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 30'h100 + 30'(i), 1'b0, 1'b0, '0);
      check("fill");
    end
    vectors++;
    assert (level === 3'd4 && cpu_x1 === 1'b0) else begin
      errors++;
      $error("FAIL full_flags observed level=%0d x1=%0b expected level=4 x1=0", level, cpu_x1);
    end
    step(1'b1, 30'h3FFF_FFFF, 1'b0, 1'b0, '0);
    check("write_when_full");
    vectors++;
    assert (overflow === ovf_enabled()) else begin
      errors++;
      $error("FAIL overflow_flag observed=%0b expected=%0b", overflow, ovf_enabled());
    end

    // Full plus pop in the same cycle: the write is refused.
    step(1'b1, 30'h0123_4567, 1'b1, 1'b0, '0);
    check("full_pop");
    vectors++;
    assert (level === 3'd3 && cpu_x1 === 1'b1) else begin
      errors++;
      $error("FAIL full_pop_flags observed level=%0d x1=%0b expected level=3 x1=1", level, cpu_x1);
    end
    while (q.size() != 0) begin
      got = q[0];
      vectors++;
      assert (host_rd_data !== 30'h0123_4567 && host_rd_data === got) else begin
        errors++;
        $error("FAIL full_pop_absent observed=%h expected=%h", host_rd_data, got);
      end
      step(1'b0, '0, 1'b1, 1'b0, '0);
    end
    check("drained");

    // Empty plus push with ready held: visible only after the edge.
    cpu_y1 = 1'b1;
    cpu_y2 = 30'h00AB_CDEF;
    host_rd_ready = 1'b1;
    #1;
    vectors++;
    assert (host_rd_valid === 1'b0) else begin
      errors++;
      $error("FAIL empty_push_pre observed=%0b expected=0", host_rd_valid);
    end
    step(1'b1, 30'h00AB_CDEF, 1'b1, 1'b0, '0);
    check("empty_push_visible");
    step(1'b0, '0, 1'b1, 1'b0, '0);
    check("empty_push_popped");

    // Host-to-CPU word held through idle cycles, pushes and pops.
    step(1'b0, '0, 1'b0, 1'b1, 30'h2AAA_AAAA);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, '0);
      check("x2_idle");
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 30'h55 + 30'(i), (i % 2 == 1), 1'b0, '0);
      check("x2_traffic");
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      w = 30'($urandom);
      step(($urandom_range(0, 3) != 0), w, ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 9) == 0), 30'($urandom));
      check("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu_io_responder.md
# cpu_io_responder

Device-side responder for the `cpu_top` external I/O port: the 1-bit strobe plus 30-bit word the CPU drives out, and the 1-bit ready plus 30-bit word it samples in.
- CPU output words are buffered in a small first-word-fall-through FIFO, which a host/peripheral drains through a valid/ready port.
- The host loads the 30-bit word returned to the CPU, and the responder drives the CPU's ready input from FIFO space.
- It sits beside `cpu_top` in the system top and replaces fixed tie-offs of the CPU input port.

## Interface
Parameters:
- DATA_W, 30, width of CPU I/O words (matches `cpu_top` port).
- DEPTH, 4, FIFO entries; power of two, ≥2.
- AW, 2, log2(DEPTH).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_y1  in  1  CPU write strobe (from `cpu_top` y1).
- cpu_y2  in  DATA_W  CPU write word (from `cpu_top` y2).
- cpu_x1  out  1  ready to CPU (to `cpu_top` x1): 1 = FIFO not full.
- cpu_x2  out  DATA_W  input word to CPU (to `cpu_top` x2).
- host_rd_valid  out  1  FIFO head valid.
- host_rd_data  out  DATA_W  FIFO head word.
- host_rd_ready  in  1  host consumes head.
- host_wr_en  in  1  load cpu_x2 register.
- host_wr_data  in  DATA_W  value for cpu_x2.
- level  out  AW+1  current FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky dropped-write flag (see Configuration).

## Operation
- State:
  - storage mem[DEPTH]
  - rd_ptr, wr_ptr (AW bits, wrap modulo DEPTH)
  - count (AW+1 bits)
  - x2_reg
  - ovf_reg
- full = (count == DEPTH); empty = (count == 0). Both are derived from registered count only.
- cpu_x1 = !full, combinational from registered state.
- Push: cpu_y1 && !full. Writes mem[wr_ptr] = cpu_y2 and increments wr_ptr.
- Pop: host_rd_valid && host_rd_ready. Increments rd_ptr.
- host_rd_valid = !empty; host_rd_data = mem[rd_ptr] (fall-through, no read latency).
- count update:
  - +1 on push only
  - −1 on pop only
  - unchanged on push and pop together, or on neither.
- Full plus pop in the same cycle: push is refused because cpu_x1 was 0 that cycle. The CPU must re-present the word.
- Empty plus cpu_y1: pop is impossible because valid = 0. The word becomes visible the next cycle.
- Pointer wrap: DEPTH−1 → 0; no special case.
- cpu_x2 = x2_reg. Loaded from host_wr_data on host_wr_en; otherwise held.
- cpu_y2 is ignored when cpu_y1 = 0.
- host_rd_ready is ignored when host_rd_valid = 0.

## Timing
- Reset (rst = 0, asynchronous assert):
  - rd_ptr = wr_ptr = count = 0
  - x2_reg = 0, ovf_reg = 0
  - mem contents don't-care
- Output values during reset:
  - cpu_x1 = 1
  - cpu_x2 = 0
  - host_rd_valid = 0
  - level = 0
  - overflow = 0
- Deassertion is synchronous to the next clk edge, i.e. the release is registered by the system reset synchronizer.
- Reset mid-operation: all buffered words are discarded immediately and the flags return to reset values with no clock needed.
- Push at edge N: host_rd_valid and level reflect it after edge N.
- CPU-to-host latency: 1 cycle.
- Pop at edge N: head advances after edge N.
- host_wr_en at edge N: cpu_x2 shows the new value after edge N.
- cpu_x1 drops in the cycle after the push that fills the FIFO. It rises in the cycle after the first pop from full.
- Throughput: one push and one pop per cycle sustained when neither full nor empty.

## Configuration
- Macro: `CPU_IO_OVF_EN`.
- Defined:
  - ovf_reg sets on any cycle with cpu_y1 = 1 && full. The write is dropped.
  - ovf_reg stays set until reset; pops do not clear it.
  - overflow = ovf_reg.
- Undefined:
  - No ovf_reg is synthesized and overflow is tied to 0.
  - Writes while full are dropped silently.
- FIFO behaviour is identical in both builds.

## Test plan
- Reset: assert rst = 0 mid-stream after 3 pushes → immediately cpu_x1 = 1, host_rd_valid = 0, level = 0, cpu_x2 = 0, overflow = 0.
- Ordering and wrap: push 0x0000001..0x0000006 with host_rd_ready = 1 from the second push onward → host sees the same order, level never exceeds 2, pointers wrap with no loss.
- Full boundary:
  - With host_rd_ready = 0, push 4 words → level = 4, cpu_x1 = 0.
  - Fifth cpu_y1 with 0x3FFFFFFF → not stored; level stays 4.
  - With the macro, overflow = 1 next cycle; without it, overflow stays 0.
- Full plus pop in the same cycle: level = 4, host_rd_ready = 1, cpu_y1 = 1 → level = 3 after the edge, the pushed word is absent, and cpu_x1 = 1 next cycle.
- Empty plus push: cpu_y1 = 1 with 0x0ABCDEF at edge N, host_rd_ready = 1 → host_rd_valid = 1 with host_rd_data = 0x0ABCDEF only after edge N; popped at edge N+1.
- Host-to-CPU word: host_wr_en = 1 with 0x2AAAAAAA → cpu_x2 = 0x2AAAAAAA next cycle, held for 10 idle cycles, and unaffected by pushes and pops.
